// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: selects the next PC by priority, raises pipeline flushes, captures EPC
// and latches edge-triggered, maskable interrupts with per-channel vectors.
module pc_redirect_unit #(
  parameter int unsigned         XLEN      = 32,
  parameter int unsigned         NUM_IRQ   = 4,
  parameter logic [XLEN-1:0]     RESET_VEC = 32'h8000_0000,
  parameter logic [XLEN-1:0]     IRQ_BASE  = 32'h8000_0004,
  parameter logic [XLEN-1:0]     EXC_VEC   = 32'h8000_0008
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                stall_i,
  input  logic [1:0]          jump_i,
  input  logic                branch_i,
  input  logic                branch_cond_i,
  input  logic [XLEN-1:0]     jump_target_i,
  input  logic [XLEN-1:0]     jr_target_i,
  input  logic                exception_i,
  input  logic [XLEN-1:0]     exc_pc_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  irq_mask_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     pc_next_o,
  output logic [XLEN-1:0]     epc_o,
  output logic [NUM_IRQ-1:0]  irq_pending_o,
  output logic                irq_taken_o,
  output logic [3:0]          irq_id_o,
  output logic                if_id_flush_o,
  output logic                id_ex_flush_o,
  output logic                ex_mem_flush_o
);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [3:0]         irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] irq_active;
  logic               irq_any;
  logic [3:0]         irq_sel;
  logic               kernel;
  logic               irq_go;
  logic               irq_taken;
  logic               branch_taken;
  logic [XLEN-1:0]    irq_vec;
  logic [XLEN-1:0]    seq_pc;
  logic [XLEN-1:0]    tgt_pc;

  assign kernel       = pc_q[XLEN-1];
  assign irq_active   = pending_q & irq_mask_i;
  assign irq_any      = |irq_active;
  assign irq_go       = irq_any & ~kernel;
  assign irq_taken    = irq_go & ~exception_i;
  assign branch_taken = branch_i & branch_cond_i;

  // Lowest enabled pending channel wins.
  always_comb begin
    irq_sel = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_active[k]) irq_sel = 4'(k);
    end
  end

  assign irq_vec = IRQ_BASE + (XLEN'(irq_sel) << 4);
  // The increment is confined below the kernel bit; direct targets cannot drop out of kernel mode.
  assign seq_pc  = {pc_q[XLEN-1], pc_q[XLEN-2:0] + (XLEN-1)'(4)};
  assign tgt_pc  = {jump_target_i[XLEN-1] | pc_q[XLEN-1], jump_target_i[XLEN-2:0]};

  always_comb begin
    pc_d = seq_pc;
    if (exception_i)                          pc_d = EXC_VEC;
    else if (irq_go)                          pc_d = irq_vec;
    else if (stall_i)                         pc_d = pc_q;
    else if (jump_i == 2'b10)                 pc_d = jr_target_i;
    else if (jump_i == 2'b01 || branch_taken) pc_d = tgt_pc;
  end

  always_comb begin
    epc_d    = epc_q;
    irq_id_d = irq_id_q;
    if (exception_i) begin
      epc_d = exc_pc_i;
    end else if (irq_go) begin
      epc_d    = pc_q;
      irq_id_d = irq_sel;
    end
  end

  // A new rising edge on the channel being taken re-arms it in the same cycle.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
    logic rise;
    logic clr;
    assign rise          = irq_i[gi] & ~irq_q[gi];
    assign clr           = irq_taken & (irq_sel == 4'(gi));
    assign pending_d[gi] = rise | (pending_q[gi] & ~clr);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      pending_q <= '0;
      irq_q     <= '0;
      irq_id_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
      irq_q     <= irq_i;
      irq_id_q  <= irq_id_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_next_o      = pc_d;
  assign epc_o          = epc_q;
  assign irq_pending_o  = pending_q;
  assign irq_taken_o    = irq_taken;
  assign irq_id_o       = irq_id_q;
  assign if_id_flush_o  = exception_i | irq_go | ((jump_i != 2'b00) & ~stall_i) | (branch_taken & ~stall_i);
  assign id_ex_flush_o  = stall_i | exception_i | irq_go;
  assign ex_mem_flush_o = exception_i;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed scenarios plus randomized stimulus for pc_redirect_unit, checked every cycle
// against a cycle-level reference model of the redirect rules.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_BASE  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] KBIT      = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [1:0]  jump;
  logic        branch;
  logic        branch_cond;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        exception;
  logic [31:0] exc_pc;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] epc;
  logic [3:0]  irq_pending;
  logic        irq_taken;
  logic [3:0]  irq_id;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .stall_i        (stall),
    .jump_i         (jump),
    .branch_i       (branch),
    .branch_cond_i  (branch_cond),
    .jump_target_i  (jump_target),
    .jr_target_i    (jr_target),
    .exception_i    (exception),
    .exc_pc_i       (exc_pc),
    .irq_i          (irq),
    .irq_mask_i     (irq_mask),
    .pc_o           (pc),
    .pc_next_o      (pc_next),
    .epc_o          (epc),
    .irq_pending_o  (irq_pending),
    .irq_taken_o    (irq_taken),
    .irq_id_o       (irq_id),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_flush_o (ex_mem_flush)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [3:0]  m_pend, m_prev, m_id;
  logic [31:0] e_next;
  bit          e_go, e_taken, e_ifid, e_idex, e_exmem;
  int          e_sel;

  task automatic model_comb();
    bit found;
    found = 0;
    e_sel = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && m_pend[k] && irq_mask[k]) begin
        found = 1;
        e_sel = k;
      end
    end
    e_go = found && !m_pc[31];
    if (exception)                               e_next = EXC_VEC;
    else if (e_go)                               e_next = IRQ_BASE + 32'(16 * e_sel);
    else if (stall)                              e_next = m_pc;
    else if (jump == 2'b10)                      e_next = jr_target;
    else if (jump == 2'b01 || (branch && branch_cond))
                                                 e_next = jump_target | (m_pc & KBIT);
    else                                         e_next = (m_pc & KBIT) | ((m_pc + 32'd4) & ~KBIT);
    e_taken = e_go && !exception;
    e_ifid  = exception || e_go || (jump != 2'b00 && !stall) || (branch && branch_cond && !stall);
    e_idex  = stall || exception || e_go;
    e_exmem = exception;
  endtask

  task automatic model_update();
    if (!reset_n) begin
      m_pc = RESET_VEC; m_epc = '0; m_pend = '0; m_prev = '0; m_id = '0;
    end else begin
      if (exception) m_epc = exc_pc;
      else if (e_go) m_epc = m_pc;
      if (e_taken) begin
        m_id = 4'(e_sel);
        m_pend[e_sel] = 1'b0;
      end
      m_pend = m_pend | (irq & ~m_prev);
      m_prev = irq;
      m_pc   = e_next;
    end
  endtask

  task automatic check_all();
    chk("pc",           pc,                  m_pc);
    chk("pc_next",      pc_next,             e_next);
    chk("epc",          epc,                 m_epc);
    chk("pending",      32'(irq_pending),    32'(m_pend));
    chk("irq_taken",    32'(irq_taken),      32'(e_taken));
    chk("irq_id",       32'(irq_id),         32'(m_id));
    chk("if_id_flush",  32'(if_id_flush),    32'(e_ifid));
    chk("id_ex_flush",  32'(id_ex_flush),    32'(e_idex));
    chk("ex_mem_flush", 32'(ex_mem_flush),   32'(e_exmem));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 0; jump = 2'b00; branch = 0; branch_cond = 0;
    jump_target = '0; jr_target = '0; exception = 0; exc_pc = '0;
    irq = '0; irq_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = RESET_VEC; m_epc = '0; m_pend = '0; m_prev = '0; m_id = '0;
    reset_n = 1'b1;

    // T1: sequential fetch out of reset
    #2;
    chk("t1_pc0", pc, 32'h8000_0000);
    chk("t1_flush", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'd0);
    cycle();
    chk("t1_pc1", pc, 32'h8000_0004);
    cycle();
    chk("t1_pc2", pc, 32'h8000_0008);
    $display("T1 reset release sequence done");

    // T2: direct jump from user space
    jump = 2'b10; jr_target = 32'h0040_0000;
    cycle();
    jump = 2'b01; jump_target = 32'h0040_0100;
    chk("t2_pc", pc, 32'h0040_0000);
    #2;
    chk("t2_pc_next", pc_next, 32'h0040_0100);
    chk("t2_if_id", 32'(if_id_flush), 32'd1);
    cycle();
    jump = 2'b00;
    chk("t2_pc_after", pc, 32'h0040_0100);
    $display("T2 jump redirect done");

    // T3: stall dominates a taken branch
    stall = 1; branch = 1; branch_cond = 1; jump_target = 32'h0040_0800;
    #2;
    chk("t3_pc_next", pc_next, 32'h0040_0100);
    chk("t3_id_ex", 32'(id_ex_flush), 32'd1);
    chk("t3_if_id", 32'(if_id_flush), 32'd0);
    cycle();
    stall = 0; branch = 0; branch_cond = 0;
    chk("t3_pc_held", pc, 32'h0040_0100);
    $display("T3 stall hold done");

    // T4: user-mode interrupt on channel 2
    jump = 2'b10; jr_target = 32'h0040_0010; irq = 4'b0100; irq_mask = 4'b1111;
    cycle();
    jump = 2'b00;
    chk("t4_pc", pc, 32'h0040_0010);
    chk("t4_pend_set", 32'(irq_pending), 32'h4);
    #2;
    chk("t4_pc_next", pc_next, 32'h8000_0024);
    chk("t4_taken", 32'(irq_taken), 32'd1);
    cycle();
    chk("t4_pc_vec", pc, 32'h8000_0024);
    chk("t4_epc", epc, 32'h0040_0010);
    chk("t4_id", 32'(irq_id), 32'd2);
    chk("t4_pend_clr", 32'(irq_pending), 32'd0);
    $display("T4 interrupt channel 2 done");

    // T5: interrupt held in kernel, taken after eret
    irq = 4'b0110;
    cycle();
    chk("t5_pend", 32'(irq_pending), 32'h2);
    chk("t5_pc_kernel", pc, 32'h8000_0028);
    jump = 2'b10; jr_target = 32'h0040_0020;
    #2;
    chk("t5_no_take", 32'(irq_taken), 32'd0);
    cycle();
    jump = 2'b00;
    chk("t5_pc_user", pc, 32'h0040_0020);
    #2;
    chk("t5_pc_next", pc_next, 32'h8000_0014);
    cycle();
    chk("t5_pc_vec", pc, 32'h8000_0014);
    chk("t5_epc", epc, 32'h0040_0020);
    chk("t5_id", 32'(irq_id), 32'd1);
    $display("T5 kernel-deferred interrupt done");

    // T6: exception beats a simultaneous interrupt edge
    irq = 4'b0000; jump = 2'b10; jr_target = 32'h0040_0030;
    cycle();
    jump = 2'b00; exception = 1; exc_pc = 32'h0040_0040; irq = 4'b0001;
    #2;
    chk("t6_ex_mem", 32'(ex_mem_flush), 32'd1);
    chk("t6_pc_next", pc_next, 32'h8000_0008);
    chk("t6_no_take", 32'(irq_taken), 32'd0);
    cycle();
    exception = 0;
    chk("t6_pc", pc, 32'h8000_0008);
    chk("t6_epc", epc, 32'h0040_0040);
    chk("t6_pend", 32'(irq_pending), 32'h1);
    jump = 2'b10; jr_target = 32'h0040_0050;
    cycle();
    jump = 2'b00;
    #2;
    chk("t6_late_take", pc_next, 32'h8000_0004);
    cycle();
    chk("t6_late_id", 32'(irq_id), 32'd0);
    $display("T6 exception priority done");

    // Sequential wrap stays in user space
    jump = 2'b10; jr_target = 32'h7fff_fffc;
    cycle();
    jump = 2'b00;
    cycle();
    chk("wrap_pc", pc, 32'h0000_0000);
    $display("user wrap done");

    // Reset during a redirect
    exception = 1; exc_pc = 32'h0040_0060; irq = 4'b1010; reset_n = 0;
    cycle();
    exception = 0; reset_n = 1;
    chk("rst_pc", pc, RESET_VEC);
    chk("rst_epc", epc, 32'd0);
    chk("rst_pend", 32'(irq_pending), 32'd0);
    $display("reset mid-redirect done");

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 100; i++) begin
        reset_n     = ($urandom_range(0, 59) != 0);
        stall       = ($urandom_range(0, 3) == 0);
        jump        = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) jump = 2'b00;
        branch      = ($urandom_range(0, 2) == 0);
        branch_cond = ($urandom_range(0, 1) == 0);
        jump_target = {1'b0, 29'($urandom), 2'b00};
        jr_target   = {($urandom_range(0, 7) == 0), 29'($urandom), 2'b00};
        exception   = ($urandom_range(0, 15) == 0);
        exc_pc      = {1'b0, 29'($urandom), 2'b00};
        irq         = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
        if ($urandom_range(0, 7) == 0) irq_mask = 4'($urandom);
        cycle();
      end
      $display("random block %0d done: %0d checks so far", blk, n_checks);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
